// File: rtl/dm_arbiter.sv
// Arbiter for the single-port data memory: CPU load/store port vs DMA/bridge word port.
// Ack lands one cycle after req from idle, then back-to-back while ownership holds; burst cap hands over.
module dm_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_lb,
   input  logic              cpu_sb,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,

   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_ack,

   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_din,
   output logic              dm_we,
   output logic              dm_lb,
   output logic              dm_sb,
   input  logic [DATA_W-1:0] dm_dout
);

   localparam int                CNT_W     = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_BURST - 1);
   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   owner_t           owner;
   owner_t           owner_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         owner <= OWN_IDLE;
         cnt   <= '0;
      end else begin
         owner <= owner_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // cnt only runs while the non-owner is waiting; any uncontested cycle clears it.
   always_comb begin
      owner_nxt = owner;
      cnt_nxt   = '0;
      case (owner)
         OWN_IDLE: begin
            if (cpu_req)      owner_nxt = OWN_CPU;
            else if (dma_req) owner_nxt = OWN_DMA;
         end
         OWN_CPU: begin
            if (!cpu_req)                        owner_nxt = dma_req ? OWN_DMA : OWN_IDLE;
            else if (dma_req && cnt == CNT_LAST) owner_nxt = OWN_DMA;
            else if (dma_req)                    cnt_nxt   = cnt + CNT_W'(1);
         end
         OWN_DMA: begin
            if (!dma_req)                        owner_nxt = cpu_req ? OWN_CPU : OWN_IDLE;
            else if (cpu_req && cnt == CNT_LAST) owner_nxt = OWN_CPU;
            else if (cpu_req)                    cnt_nxt   = cnt + CNT_W'(1);
         end
         default: owner_nxt = OWN_IDLE;
      endcase
   end

   // Reset masks every access so no write can commit on the reset edge.
   always_comb begin
      cpu_ack = 1'b0;
      dma_ack = 1'b0;
      dm_addr = '0;
      dm_din  = '0;
      dm_we   = 1'b0;
      dm_lb   = 1'b0;
      dm_sb   = 1'b0;
      if (!reset) begin
         if (owner == OWN_CPU && cpu_req) begin
            cpu_ack = 1'b1;
            dm_addr = cpu_addr;
            dm_din  = cpu_wdata;
            dm_we   = cpu_we;
            dm_lb   = cpu_lb;
            dm_sb   = cpu_sb;
         end else if (owner == OWN_DMA && dma_req) begin
            dma_ack = 1'b1;
            dm_addr = dma_addr & WORD_MASK;
            dm_din  = dma_wdata;
            dm_we   = dma_we;
         end
      end
   end

   assign cpu_rdata = dm_dout;
   assign dma_rdata = dm_dout;
   assign cpu_stall = cpu_req & ~cpu_ack;

   a_single_grant: assert property (@(posedge clk) !(cpu_ack && dma_ack));
   a_write_granted: assert property (@(posedge clk) dm_we |-> (cpu_ack || dma_ack));

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter with a byte-addressed memory standing in for dm_1k.
`timescale 1ns/1ps
module tb_dm_arbiter;
   localparam int ADDR_W = 12;
   localparam int DATA_W = 32;
   localparam int MB     = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              cpu_req, cpu_we, cpu_lb, cpu_sb;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              cpu_ack, cpu_stall;
   logic              dma_req, dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata, dma_rdata;
   logic              dma_ack;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_din, dm_dout;
   logic              dm_we, dm_lb, dm_sb;

   int n_checks = 0;
   int n_fail   = 0;

   dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lb(cpu_lb), .cpu_sb(cpu_sb),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_ack(dma_ack),
      .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_lb(dm_lb), .dm_sb(dm_sb),
      .dm_dout(dm_dout)
   );

   always #5 clk = ~clk;

   // dm_1k stand-in: little-endian bytes, combinational read, write on the edge.
   logic [7:0] mem [0:1023];
   logic       mem_clr;
   logic [9:0] wa;
   assign wa = {dm_addr[9:2], 2'b00};

   always_comb begin
      if (dm_lb) dm_dout = {{24{mem[dm_addr[9:0]][7]}}, mem[dm_addr[9:0]]};
      else       dm_dout = {mem[wa + 10'd3], mem[wa + 10'd2], mem[wa + 10'd1], mem[wa]};
   end

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (dm_we) begin
         if (dm_sb) mem[dm_addr[9:0]] <= dm_din[7:0];
         else begin
            mem[wa]         <= dm_din[7:0];
            mem[wa + 10'd1] <= dm_din[15:8];
            mem[wa + 10'd2] <= dm_din[23:16];
            mem[wa + 10'd3] <= dm_din[31:24];
         end
      end
   end

   // Reference: who is owner, how many grants it has had while contested, expected memory.
   int         m_owner = 0;   // 0 none, 1 cpu, 2 dma
   int         m_run   = 0;
   logic [7:0] refm [0:1023];
   logic       last_cack = 1'b0;
   logic       last_dack = 1'b0;

   function automatic logic e_cack();
      return !reset && m_owner == 1 && cpu_req;
   endfunction
   function automatic logic e_dack();
      return !reset && m_owner == 2 && dma_req;
   endfunction
   function automatic logic [31:0] ref_word(input logic [11:0] a);
      int b;
      b = int'({a[9:2], 2'b00});
      return {refm[b + 3], refm[b + 2], refm[b + 1], refm[b]};
   endfunction
   function automatic logic [31:0] ref_byte(input logic [11:0] a);
      logic [7:0] v;
      v = refm[a[9:0]];
      return {{24{v[7]}}, v};
   endfunction
   function automatic logic [31:0] mem_word(input logic [11:0] a);
      int b;
      b = int'({a[9:2], 2'b00});
      return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
   endfunction
   function automatic void ref_store_word(input logic [11:0] a, input logic [31:0] d);
      int b;
      b = int'({a[9:2], 2'b00});
      refm[b] = d[7:0]; refm[b + 1] = d[15:8]; refm[b + 2] = d[23:16]; refm[b + 3] = d[31:24];
   endfunction

   task automatic advance();
      logic ca, da, own, oth;
      @(posedge clk);
      ca = e_cack();
      da = e_dack();
      if (reset) begin
         m_owner = 0;
         m_run   = 0;
      end else begin
         if (ca && cpu_we) begin
            if (cpu_sb) refm[cpu_addr[9:0]] = cpu_wdata[7:0];
            else        ref_store_word(cpu_addr, cpu_wdata);
         end
         if (da && dma_we) ref_store_word(dma_addr, dma_wdata);
         if (m_owner == 0) begin
            m_owner = cpu_req ? 1 : (dma_req ? 2 : 0);
            m_run   = 0;
         end else begin
            own = (m_owner == 1) ? cpu_req : dma_req;
            oth = (m_owner == 1) ? dma_req : cpu_req;
            if (!own) begin
               m_owner = oth ? 3 - m_owner : 0;
               m_run   = 0;
            end else if (oth) begin
               m_run++;
               if (m_run == MB) begin
                  m_owner = 3 - m_owner;
                  m_run   = 0;
               end
            end else m_run = 0;
         end
      end
      last_cack = ca;
      last_dack = da;
      #1;
   endtask

   task automatic idle(input int n);
      cpu_req = 0; cpu_we = 0; cpu_lb = 0; cpu_sb = 0;
      dma_req = 0; dma_we = 0;
      repeat (n) advance();
   endtask

   task automatic cpu_access(input logic we, lb, sb, input logic [11:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int lat, output logic got,
                             output logic we_seen, lb_seen, sb_seen, stray, output logic [11:0] addr_seen);
      cpu_req = 1; cpu_we = we; cpu_lb = lb; cpu_sb = sb; cpu_addr = addr; cpu_wdata = wdata;
      lat = 0; got = 0; stray = 0; rdata = '0;
      we_seen = 0; lb_seen = 0; sb_seen = 0; addr_seen = '0;
      while (!got && lat < 20) begin
         @(negedge clk);
         if (cpu_ack) begin
            got = 1; rdata = cpu_rdata; we_seen = dm_we; lb_seen = dm_lb; sb_seen = dm_sb; addr_seen = dm_addr;
         end else begin
            stray = stray | dm_we | dm_lb | dm_sb;
            lat++;
         end
         advance();
      end
      cpu_req = 0; cpu_we = 0; cpu_lb = 0; cpu_sb = 0;
   endtask

   task automatic dma_access(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata, output int lat, output logic got,
                             output logic [11:0] addr_seen, output logic bytes_seen);
      dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      lat = 0; got = 0; rdata = '0; addr_seen = '0; bytes_seen = 0;
      while (!got && lat < 20) begin
         @(negedge clk);
         if (dma_ack) begin
            got = 1; rdata = dma_rdata; addr_seen = dm_addr; bytes_seen = dm_lb | dm_sb;
         end else lat++;
         advance();
      end
      dma_req = 0; dma_we = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 1024; i++) refm[i] = 8'h00;
      mem_clr = 1; reset = 1;
      cpu_req = 1; cpu_we = 1; cpu_lb = 0; cpu_sb = 0; cpu_addr = 12'h004; cpu_wdata = 32'h1;
      dma_req = 1; dma_we = 1; dma_addr = 12'h008; dma_wdata = 32'h2;
      @(negedge clk);
      n_checks++; if (cpu_ack !== 1'b0)  begin n_fail++; $display("FAIL reset cpu_ack got=%b exp=0", cpu_ack); end
      n_checks++; if (dma_ack !== 1'b0)  begin n_fail++; $display("FAIL reset dma_ack got=%b exp=0", dma_ack); end
      n_checks++; if (dm_we !== 1'b0)    begin n_fail++; $display("FAIL reset dm_we got=%b exp=0", dm_we); end
      n_checks++; if (dm_addr !== 12'h0) begin n_fail++; $display("FAIL reset dm_addr got=%h exp=000", dm_addr); end
      n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset cpu_stall got=%b exp=1", cpu_stall); end
      advance(); advance();
      idle(1);
      mem_clr = 0; reset = 0;
      idle(1);
   endtask

   task automatic test_cpu_word();
      logic [31:0] rd; int lat; logic got, we_s, lb_s, sb_s, stray; logic [11:0] a_s;
      cpu_access(1, 0, 0, 12'h010, 32'hDEADBEEF, rd, lat, got, we_s, lb_s, sb_s, stray, a_s);
      n_checks++; if (!got || lat != 1) begin n_fail++; $display("FAIL sw latency got=%0d ack=%b exp=1", lat, got); end
      n_checks++; if (we_s !== 1'b1)    begin n_fail++; $display("FAIL sw dm_we got=%b exp=1", we_s); end
      n_checks++; if (a_s !== 12'h010)  begin n_fail++; $display("FAIL sw dm_addr got=%h exp=010", a_s); end
      idle(2);
      cpu_access(0, 0, 0, 12'h010, 32'h0, rd, lat, got, we_s, lb_s, sb_s, stray, a_s);
      n_checks++; if (!got || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw rdata got=%h exp=deadbeef", rd); end
      n_checks++; if (we_s !== 1'b0)    begin n_fail++; $display("FAIL lw dm_we got=%b exp=0", we_s); end
   endtask

   task automatic test_byte();
      logic [31:0] rd; int lat; logic got, we_s, lb_s, sb_s, stray; logic [11:0] a_s;
      idle(2);
      cpu_access(1, 0, 1, 12'h013, 32'h12345680, rd, lat, got, we_s, lb_s, sb_s, stray, a_s);
      n_checks++; if (!got || sb_s !== 1'b1 || lb_s !== 1'b0) begin n_fail++; $display("FAIL sb flags got sb=%b lb=%b exp sb=1 lb=0", sb_s, lb_s); end
      n_checks++; if (stray !== 1'b0) begin n_fail++; $display("FAIL sb stray flags outside ack got=%b exp=0", stray); end
      idle(2);
      cpu_access(0, 1, 0, 12'h013, 32'h0, rd, lat, got, we_s, lb_s, sb_s, stray, a_s);
      n_checks++; if (!got || rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb rdata got=%h exp=ffffff80", rd); end
      n_checks++; if (lb_s !== 1'b1 || sb_s !== 1'b0 || stray !== 1'b0) begin n_fail++; $display("FAIL lb flags got lb=%b sb=%b stray=%b exp 1 0 0", lb_s, sb_s, stray); end
      cpu_access(0, 0, 0, 12'h010, 32'h0, rd, lat, got, we_s, lb_s, sb_s, stray, a_s);
      n_checks++; if (rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL sb byte lane got=%h exp=80adbeef", rd); end
   endtask

   task automatic test_alternate();
      logic exp_cpu;
      idle(2);
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
      dma_req = 1; dma_we = 0; dma_addr = 12'h020;
      @(negedge clk);
      n_checks++; if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin n_fail++; $display("FAIL alt idle cycle got c=%b d=%b exp 0 0", cpu_ack, dma_ack); end
      advance();
      for (int i = 0; i < 3 * MB; i++) begin
         @(negedge clk);
         exp_cpu = ((i / MB) % 2) == 0;
         n_checks++;
         if ({cpu_ack, dma_ack} !== {exp_cpu, ~exp_cpu}) begin
            n_fail++; $display("FAIL alt grant cycle %0d got c=%b d=%b exp c=%b d=%b", i, cpu_ack, dma_ack, exp_cpu, ~exp_cpu);
         end
         advance();
      end
      idle(1);
   endtask

   task automatic test_dma_align();
      logic [31:0] rd; int lat; logic got, bytes_s, we_s, lb_s, sb_s, stray; logic [11:0] a_s;
      idle(2);
      dma_access(1, 12'h021, 32'h55AA00FF, rd, lat, got, a_s, bytes_s);
      n_checks++; if (!got || lat != 1) begin n_fail++; $display("FAIL dma latency got=%0d ack=%b exp=1", lat, got); end
      n_checks++; if (a_s !== 12'h020 || bytes_s !== 1'b0) begin n_fail++; $display("FAIL dma addr got=%h bytes=%b exp=020 0", a_s, bytes_s); end
      cpu_access(0, 0, 0, 12'h020, 32'h0, rd, lat, got, we_s, lb_s, sb_s, stray, a_s);
      n_checks++; if (rd !== 32'h55AA00FF) begin n_fail++; $display("FAIL dma->cpu readback got=%h exp=55aa00ff", rd); end
      dma_access(0, 12'h023, 32'h0, rd, lat, got, a_s, bytes_s);
      n_checks++; if (rd !== 32'h55AA00FF) begin n_fail++; $display("FAIL dma readback got=%h exp=55aa00ff", rd); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; int lat; logic got, we_s, lb_s, sb_s, stray; logic [11:0] a_s;
      cpu_access(1, 0, 0, 12'h040, 32'h11111111, rd, lat, got, we_s, lb_s, sb_s, stray, a_s);
      idle(2);
      cpu_req = 1; cpu_we = 1; cpu_addr = 12'h040; cpu_wdata = 32'hCAFEF00D;
      advance();
      reset = 1;
      @(negedge clk);
      n_checks++; if (cpu_ack !== 1'b0 || dm_we !== 1'b0) begin n_fail++; $display("FAIL midrst ack/we got=%b/%b exp 0/0", cpu_ack, dm_we); end
      n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL midrst stall got=%b exp=1", cpu_stall); end
      advance();
      n_checks++; if (mem_word(12'h040) !== 32'h11111111) begin n_fail++; $display("FAIL midrst memory got=%h exp=11111111", mem_word(12'h040)); end
      reset = 0;
      @(negedge clk);
      n_checks++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL midrst first cycle ack got=%b exp=0", cpu_ack); end
      advance();
      @(negedge clk);
      n_checks++; if (cpu_ack !== 1'b1) begin n_fail++; $display("FAIL midrst re-arb ack got=%b exp=1", cpu_ack); end
      advance();
      idle(1);
      cpu_access(0, 0, 0, 12'h040, 32'h0, rd, lat, got, we_s, lb_s, sb_s, stray, a_s);
      n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midrst readback got=%h exp=cafef00d", rd); end
   endtask

   task automatic test_cpu_only();
      int acks = 0, stalls = 0;
      idle(2);
      cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         if (cpu_ack) acks++;
         if (cpu_stall) stalls++;
         if (i == 0) begin
            n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL solo first stall got=%b exp=1", cpu_stall); end
         end else begin
            n_checks++; if (cpu_ack !== 1'b1 || dut.cnt !== '0) begin n_fail++; $display("FAIL solo cycle %0d ack=%b cnt=%0d exp ack=1 cnt=0", i, cpu_ack, dut.cnt); end
         end
         advance();
      end
      idle(1);
      n_checks++; if (acks != 10)  begin n_fail++; $display("FAIL solo ack count got=%0d exp=10", acks); end
      n_checks++; if (stalls != 1) begin n_fail++; $display("FAIL solo stall count got=%0d exp=1", stalls); end
   endtask

   task automatic test_random();
      logic ec, ed;
      logic [31:0] er;
      int kind;
      idle(2);
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (!cpu_req || last_cack) begin
            if ($urandom_range(99) < 60) begin
               kind = $urandom_range(3);
               cpu_req = 1; cpu_we = kind[0]; cpu_lb = (kind == 2); cpu_sb = (kind == 3);
               cpu_addr = 12'($urandom_range(63));
               if (kind < 2) cpu_addr[1:0] = 2'b00;
               cpu_wdata = $urandom;
            end else begin
               cpu_req = 0; cpu_we = 0; cpu_lb = 0; cpu_sb = 0;
            end
         end else if ($urandom_range(99) < 5) begin
            cpu_req = 0; cpu_we = 0; cpu_lb = 0; cpu_sb = 0;
         end
         if (!dma_req || last_dack) begin
            dma_req = ($urandom_range(99) < 60);
            dma_we = $urandom_range(1); dma_addr = 12'($urandom_range(63)); dma_wdata = $urandom;
         end else if ($urandom_range(99) < 5) dma_req = 0;

         @(negedge clk);
         ec = e_cack(); ed = e_dack();
         n_checks++; if (cpu_ack !== ec) begin n_fail++; $display("FAIL rnd cpu_ack cyc=%0d got=%b exp=%b", cyc, cpu_ack, ec); end
         n_checks++; if (dma_ack !== ed) begin n_fail++; $display("FAIL rnd dma_ack cyc=%0d got=%b exp=%b", cyc, dma_ack, ed); end
         n_checks++; if (cpu_stall !== (cpu_req & ~ec)) begin n_fail++; $display("FAIL rnd stall cyc=%0d got=%b exp=%b", cyc, cpu_stall, cpu_req & ~ec); end
         n_checks++; if (dm_we !== ((ec & cpu_we) | (ed & dma_we))) begin n_fail++; $display("FAIL rnd dm_we cyc=%0d got=%b", cyc, dm_we); end
         n_checks++; if ({dm_lb, dm_sb} !== {ec & cpu_lb, ec & cpu_sb}) begin n_fail++; $display("FAIL rnd lb/sb cyc=%0d got=%b%b", cyc, dm_lb, dm_sb); end
         if (ec) begin
            n_checks++; if (dm_addr !== cpu_addr) begin n_fail++; $display("FAIL rnd cpu addr cyc=%0d got=%h exp=%h", cyc, dm_addr, cpu_addr); end
            if (cpu_we) begin
               n_checks++; if (dm_din !== cpu_wdata) begin n_fail++; $display("FAIL rnd cpu din cyc=%0d got=%h exp=%h", cyc, dm_din, cpu_wdata); end
            end else begin
               er = cpu_lb ? ref_byte(cpu_addr) : ref_word(cpu_addr);
               n_checks++; if (cpu_rdata !== er) begin n_fail++; $display("FAIL rnd cpu rdata cyc=%0d got=%h exp=%h", cyc, cpu_rdata, er); end
            end
         end else if (ed) begin
            n_checks++; if (dm_addr !== {dma_addr[11:2], 2'b00}) begin n_fail++; $display("FAIL rnd dma addr cyc=%0d got=%h", cyc, dm_addr); end
            if (!dma_we) begin
               er = ref_word(dma_addr);
               n_checks++; if (dma_rdata !== er) begin n_fail++; $display("FAIL rnd dma rdata cyc=%0d got=%h exp=%h", cyc, dma_rdata, er); end
            end
         end else begin
            n_checks++; if (dm_addr !== '0 || dm_din !== '0) begin n_fail++; $display("FAIL rnd idle port cyc=%0d addr=%h din=%h exp 0", cyc, dm_addr, dm_din); end
         end
         advance();
      end
      idle(2);
   endtask

   initial begin
      test_reset();
      test_cpu_word();
      test_byte();
      test_alternate();
      test_dma_align();
      test_reset_mid();
      test_cpu_only();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
